// File: rtl/shared_mem_arbiter_pkg.sv
// shared_mem_arbiter_pkg: address map defaults, CPU miss value and arbiter state encoding.
package shared_mem_arbiter_pkg;
    localparam logic [31:0] BASE_DEF      = 32'h0000_4000;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_C010;
    localparam logic [31:0] MISS_DATA     = 32'h0000_DEAD;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
endpackage

// File: rtl/shared_mem_arbiter_starve_mon.sv
// arb_starve_mon: counts DMA wait cycles (saturating at STARVE) and the number of starvation events.
// Ports: clk, rst (sync, active high), dma_req, dma_ack in; starve_events[15:0] out (saturating).
module arb_starve_mon
    import shared_mem_arbiter_pkg::*;
#(
    parameter int STARVE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_req,
    input  logic        dma_ack,
    output logic [15:0] starve_events
);
    localparam int WW = $clog2(STARVE + 1);
    localparam logic [WW-1:0] WMAX = WW'(STARVE);
    logic [WW-1:0] wait_cnt;
    logic waiting;
    assign waiting = dma_req && !dma_ack && wait_cnt != WMAX;
    // An event is counted only on the step that brings wait_cnt onto the saturation value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            starve_events <= '0;
        end else begin
            wait_cnt <= dma_ack ? '0 : waiting ? wait_cnt + 1'b1 : wait_cnt;
            if (waiting && wait_cnt == WMAX - 1'b1 && starve_events != 16'hFFFF)
                starve_events <= starve_events + 1'b1;
        end
    end
endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: shares one async-read RAM between the CPU (absolute priority) and a bursting DMA.
// Ports: clk, rst (sync, active high); CPU bus cpu_addr/re/we/wdata in, cpu_rdata/cpu_hit out;
// DMA dma_req/we/addr/wdata/last in, dma_ack/dma_rdata out; RAM mem_addr/we/wdata out, mem_rdata in.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE      = BASE_DEF,
    parameter int          AW        = 12,
    parameter int          BURST_MAX = 16,
    parameter int          STARVE    = 64,
    parameter logic [31:0] STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   cpu_addr,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_hit,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    input  logic          dma_last,
    output logic          dma_ack,
    output logic [31:0]   dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    arb_state_t state, state_next;
    logic [BW-1:0] burst_cnt;
    logic [15:0] starve_events;
    logic [31:0] offset, status;
    logic enable, win_hit, stat_hit, yield;
    // Addresses below BASE wrap to huge offsets, so one upper-bits test covers both window bounds.
    assign offset   = cpu_addr - BASE;
    assign win_hit  = (cpu_re || cpu_we) && offset[31:AW] == '0;
    assign stat_hit = (cpu_re || cpu_we) && cpu_addr == STAT_ADDR;
    assign cpu_hit  = win_hit || stat_hit;
    assign status   = {starve_events, 13'b0, enable, state == GRANT, dma_req};
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    // Leave GRANT after the word that ends the transfer, fills the burst, or follows a disable.
    always_comb begin
        yield      = dma_ack && (dma_last || burst_cnt == BURST_LAST || !enable);
        state_next = (state == IDLE) ? ((dma_req && enable) ? GRANT : IDLE)
                                     : ((!dma_req || yield) ? IDLE : GRANT);
    end
    always_comb begin
        dma_ack   = !win_hit && state == GRANT && dma_req;
        mem_addr  = win_hit ? offset[AW-1:0] : dma_addr;
        mem_we    = win_hit ? cpu_we : dma_ack && dma_we;
        mem_wdata = win_hit ? cpu_wdata : dma_wdata;
        dma_rdata = mem_rdata;
        cpu_rdata = (win_hit && cpu_re) ? mem_rdata : (stat_hit && cpu_re) ? status : MISS_DATA;
    end
    // IDLE always precedes GRANT, so holding zero in IDLE clears the count on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
            enable    <= 1'b1;
        end else begin
            burst_cnt <= (state == IDLE) ? '0 : dma_ack ? burst_cnt + 1'b1 : burst_cnt;
            if (stat_hit && cpu_we) enable <= cpu_wdata[2];
        end
    end
    arb_starve_mon #(.STARVE(STARVE)) u_starve (
        .clk          (clk),
        .rst          (rst),
        .dma_req      (dma_req),
        .dma_ack      (dma_ack),
        .starve_events(starve_events)
    );
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: randomized scenarios against a transaction-level model of the arbiter.
module tb_shared_mem_arbiter;
    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam logic [31:0] STAT = 32'h0000_C010;
    localparam logic [31:0] DEAD = 32'h0000_DEAD;
    localparam int WORDS = 4096;
    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        last;
    } word_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_wdata = '0;
    logic cpu_re = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
    logic [11:0] dma_addr = '0;
    logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic cpu_hit, dma_ack, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] ram [WORDS];
    logic [31:0] exp_mem [WORDS];
    word_t dq[$];
    int tests = 0, fails = 0;
    bit m_grant, m_en;
    int m_burst, m_wait, m_starve;
    logic e_ack, e_hit, o_ack, o_hit;
    logic [31:0] e_rdata, e_drdata, o_rdata, o_drdata;

    shared_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    function automatic logic in_win(logic [31:0] a);
        return a >= BASE && a < BASE + 32'd4096;
    endfunction

    function automatic logic [31:0] status_word();
        return {m_starve[15:0], 13'b0, m_en, m_grant, dma_req};
    endfunction

    task automatic predict();
        logic [31:0] off;
        logic win, stat;
        off = cpu_addr - BASE;
        win = (cpu_re || cpu_we) && in_win(cpu_addr);
        stat = (cpu_re || cpu_we) && cpu_addr == STAT;
        e_hit = win || stat;
        e_ack = !win && m_grant && dma_req;
        e_rdata = !cpu_re ? DEAD : win ? exp_mem[off[11:0]] : stat ? status_word() : DEAD;
        e_drdata = exp_mem[dma_addr];
    endtask

    task automatic advance();
        logic [31:0] off;
        off = cpu_addr - BASE;
        if ((cpu_re || cpu_we) && in_win(cpu_addr) && cpu_we) exp_mem[off[11:0]] = cpu_wdata;
        else if (e_ack && dma_we) exp_mem[dma_addr] = dma_wdata;
        if (rst) begin
            m_grant = 0; m_en = 1; m_burst = 0; m_wait = 0; m_starve = 0;
            return;
        end
        if (e_ack) m_wait = 0;
        else if (dma_req && m_wait < 64) begin
            m_wait++;
            if (m_wait == 64 && m_starve < 65535) m_starve++;
        end
        if (!m_grant) begin
            m_grant = dma_req && m_en;
            m_burst = 0;
        end else if (!dma_req) m_grant = 0;
        else if (e_ack) begin
            m_burst++;
            if (dma_last || m_burst == 16 || !m_en) m_grant = 0;
        end
        if (cpu_we && cpu_addr == STAT) m_en = cpu_wdata[2];
    endtask

    task automatic cyc();
        if (dq.size() > 0) begin
            dma_req = 1; dma_we = dq[0].we; dma_addr = dq[0].addr;
            dma_wdata = dq[0].data; dma_last = dq[0].last;
        end else begin
            dma_req = 0; dma_we = 0; dma_last = 0;
        end
        @(negedge clk);
        predict();
        o_ack = dma_ack; o_hit = cpu_hit; o_rdata = cpu_rdata; o_drdata = dma_rdata;
        @(posedge clk);
        #1;
        advance();
        if (o_ack) void'(dq.pop_front());
    endtask

    task automatic push_xfer(int n, int base_addr, bit rand_we);
        for (int i = 0; i < n; i++)
            dq.push_back('{rand_we ? 1'($urandom) : 1'b1, 12'(base_addr + i), $urandom, i == n - 1});
    endtask

    task automatic test_reset();
        rst = 1; cpu_re = 0; cpu_we = 0;
        repeat (2) cyc();
        rst = 0;
        cpu_addr = STAT; cpu_re = 1;
        cyc();
        cpu_re = 0;
        tests++;
        if (o_rdata !== 32'h0000_0004 || o_ack !== 1'b0 || o_hit !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: status %h ack %b hit %b, want 00000004 0 1", o_rdata, o_ack, o_hit);
        end
    endtask

    task automatic test_dma_burst();
        logic [31:0] d [4];
        int first = 0, n = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            dq.push_back('{1'b1, 12'(i), d[i], i == 3});
        end
        for (int c = 1; c <= 8; c++) begin
            cyc();
            tests++;
            if (o_ack !== e_ack || o_hit !== e_hit || o_rdata !== e_rdata) begin
                fails++;
                $display("FAIL burst c%0d: ack %b want %b, hit %b want %b", c, o_ack, e_ack, o_hit, e_hit);
            end
            if (o_ack) begin
                n++;
                if (first == 0) first = c;
            end
        end
        tests++;
        if (first != 2 || n != 4) begin
            fails++;
            $display("FAIL burst_timing: first ack cycle %0d count %0d, want 2 and 4", first, n);
        end
        cpu_re = 1; cpu_addr = STAT;
        cyc();
        tests++;
        if (o_rdata[1] !== 1'b0) begin
            fails++;
            $display("FAIL burst_idle: status %h, want grant bit 0", o_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_addr = BASE + 32'(i);
            cyc();
            tests++;
            if (o_rdata !== d[i]) begin
                fails++;
                $display("FAIL burst_ram%0d: read %h, want %h", i, o_rdata, d[i]);
            end
        end
        cpu_re = 0;
    endtask

    task automatic test_cpu_preempt();
        logic [31:0] want2;
        want2 = exp_mem[2];
        push_xfer(6, 100, 1);
        for (int c = 1; c <= 10; c++) begin
            cpu_re = (c == 4); cpu_addr = BASE + 32'd2;
            cyc();
            tests++;
            if (o_ack !== e_ack || o_hit !== e_hit || o_rdata !== e_rdata ||
                (o_ack && !dma_we && o_drdata !== e_drdata)) begin
                fails++;
                $display("FAIL preempt c%0d: ack %b want %b, cpu_rdata %h want %h, dma_rdata %h want %h",
                         c, o_ack, e_ack, o_rdata, e_rdata, o_drdata, e_drdata);
            end
            if (c == 4) begin
                tests++;
                if (o_ack !== 1'b0 || o_rdata !== want2) begin
                    fails++;
                    $display("FAIL preempt_cpu: ack %b rdata %h, want 0 and %h", o_ack, o_rdata, want2);
                end
            end
            if (c == 5) begin
                tests++;
                if (o_ack !== 1'b1 || dma_addr !== 12'd102) begin
                    fails++;
                    $display("FAIL preempt_retry: ack %b addr %0d, want 1 and 102", o_ack, dma_addr);
                end
            end
        end
        cpu_re = 0;
        tests++;
        if (dq.size() != 0) begin
            fails++;
            $display("FAIL preempt_drain: %0d words left, want 0", dq.size());
        end
    endtask

    task automatic test_burst_limit();
        for (int pass = 0; pass < 2; pass++) begin
            push_xfer(20, 200, 0);
            for (int c = 1; c <= 25; c++) begin
                logic want;
                cpu_re = (pass == 1 && c == 6); cpu_addr = BASE + 32'($urandom_range(0, 4095));
                want = pass == 0 ? ((c >= 2 && c <= 17) || (c >= 19 && c <= 22))
                                 : ((c >= 2 && c <= 5) || (c >= 7 && c <= 18) || (c >= 20 && c <= 23));
                cyc();
                tests++;
                if (o_ack !== want || o_ack !== e_ack || o_rdata !== e_rdata) begin
                    fails++;
                    $display("FAIL burst_max p%0d c%0d: ack %b want %b, cpu_rdata %h want %h",
                             pass, c, o_ack, want, o_rdata, e_rdata);
                end
            end
        end
        cpu_re = 0;
    endtask

    task automatic test_starve();
        int n = 0;
        push_xfer(3, 300, 0);
        for (int c = 1; c <= 70; c++) begin
            int r;
            r = $urandom_range(0, 2);
            cpu_re = (r != 1); cpu_we = (r != 0);
            cpu_addr = BASE + 32'($urandom_range(0, 4095)); cpu_wdata = $urandom;
            cyc();
            tests++;
            if (o_ack !== 1'b0 || o_ack !== e_ack || o_rdata !== e_rdata || o_hit !== 1'b1) begin
                fails++;
                $display("FAIL starve_block c%0d: ack %b hit %b cpu_rdata %h want 0 1 %h",
                         c, o_ack, o_hit, o_rdata, e_rdata);
            end
        end
        cpu_we = 0; cpu_re = 1; cpu_addr = STAT;
        cyc();
        tests++;
        if (o_rdata[31:16] !== 16'd1 || o_rdata !== e_rdata) begin
            fails++;
            $display("FAIL starve_count: status %h, want starve field 1 (%h)", o_rdata, e_rdata);
        end
        if (o_ack) n++;
        cpu_re = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (o_ack) n++;
        end
        tests++;
        if (n != 3 || dq.size() != 0) begin
            fails++;
            $display("FAIL starve_resume: %0d acks %0d left, want 3 and 0", n, dq.size());
        end
    endtask

    task automatic test_enable();
        cpu_we = 1; cpu_addr = STAT; cpu_wdata = $urandom & ~32'h4;
        cyc();
        cpu_we = 0;
        push_xfer(2, 400, 0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            tests++;
            if (o_ack !== 1'b0 || e_ack !== 1'b0) begin
                fails++;
                $display("FAIL enable_block c%0d: ack %b, want 0", c, o_ack);
            end
        end
        cpu_we = 1; cpu_wdata = $urandom | 32'h4;
        for (int c = 0; c < 4; c++) begin
            cyc();
            cpu_we = 0;
            tests++;
            if (o_ack !== (c >= 2) || o_ack !== e_ack) begin
                fails++;
                $display("FAIL enable_grant c%0d: ack %b, want %b", c, o_ack, c >= 2);
            end
        end
        cpu_re = 1; cpu_addr = 32'h0000_C020;
        cyc();
        cpu_re = 0;
        tests++;
        if (o_rdata !== DEAD || o_hit !== 1'b0) begin
            fails++;
            $display("FAIL miss_read: rdata %h hit %b, want 0000dead 0", o_rdata, o_hit);
        end
    endtask

    task automatic test_reset_mid();
        push_xfer(10, 500, 1);
        repeat (4) cyc();
        rst = 1;
        cyc();
        rst = 0;
        cpu_re = 1; cpu_addr = STAT;
        cyc();
        cpu_re = 0;
        tests++;
        if (o_ack !== 1'b0 || o_rdata !== 32'h0000_0005) begin
            fails++;
            $display("FAIL reset_mid: ack %b status %h, want 0 00000005", o_ack, o_rdata);
        end
        for (int c = 0; c < 30 && dq.size() > 0; c++) cyc();
        tests++;
        if (dq.size() != 0) begin
            fails++;
            $display("FAIL reset_regrant: %0d words left, want 0", dq.size());
        end
    endtask

    task automatic test_random();
        int mism = 0;
        for (int c = 0; c < 600; c++) begin
            int r;
            if (dq.size() < 3 && $urandom_range(0, 3) == 0)
                push_xfer($urandom_range(1, 24), $urandom_range(0, 4095), 1);
            if ($urandom_range(0, 79) == 0) dq.delete();
            r = $urandom_range(0, 7);
            cpu_re = 0; cpu_we = 0; cpu_wdata = $urandom;
            cpu_addr = BASE + 32'($urandom_range(0, 4095));
            if (r <= 2) begin
                cpu_re = 1'($urandom); cpu_we = !cpu_re || 1'($urandom);
            end else if (r == 3) begin
                cpu_re = 1; cpu_addr = STAT;
            end else if (r == 4) begin
                cpu_we = 1; cpu_addr = STAT; cpu_wdata[2] = $urandom_range(0, 3) != 0;
            end else if (r == 5) begin
                cpu_re = 1; cpu_addr = $urandom_range(0, 1) ? BASE - 32'd1 - 32'($urandom_range(0, 15))
                                                             : BASE + 32'd4096 + 32'($urandom_range(0, 15));
            end
            cyc();
            tests++;
            if (o_ack !== e_ack || o_hit !== e_hit || o_rdata !== e_rdata ||
                (o_ack && !dma_we && o_drdata !== e_drdata)) begin
                fails++;
                $display("FAIL random c%0d: ack %b want %b, hit %b want %b, cpu_rdata %h want %h, dma_rdata %h want %h",
                         c, o_ack, e_ack, o_hit, e_hit, o_rdata, e_rdata, o_drdata, e_drdata);
            end
        end
        cpu_re = 0; cpu_we = 1; cpu_addr = STAT; cpu_wdata = 32'h4;
        cyc();
        cpu_we = 0;
        for (int c = 0; c < 200 && dq.size() > 0; c++) cyc();
        tests++;
        if (dq.size() != 0) begin
            fails++;
            $display("FAIL random_drain: %0d words left, want 0", dq.size());
        end
        repeat (2) cyc();
        for (int i = 0; i < WORDS; i++) if (ram[i] !== exp_mem[i]) mism++;
        tests++;
        if (mism != 0) begin
            fails++;
            $display("FAIL ram_contents: %0d words differ, want 0", mism);
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i] <= '0;
            exp_mem[i] = '0;
        end
        test_reset();
        test_dma_burst();
        test_cpu_preempt();
        test_burst_limit();
        test_starve();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
